rom_arbiter: RTL and testbench

//  Shares the single instruction/data ROM slave between two bus masters
//  (m0 = instruction fetch, m1 = data/DMA). Round-robin arbitration, one ROM

---
 rtl/rom_arbiter.sv | 132 +++++++++++++
 tb/tb_rom_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - round-robin arbiter sharing one ROM slave between two masters
module rom_arbiter #(
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req_n,
    input  logic [ADDR_W-1:0] m0_addr,
    output logic [DATA_W-1:0] m0_rd_data,
    output logic              m0_rdy_n,
    input  logic              m1_req_n,
    input  logic [ADDR_W-1:0] m1_addr,
    output logic [DATA_W-1:0] m1_rd_data,
    output logic              m1_rdy_n,
    output logic              rom_cs_n,
    output logic              rom_as_n,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_rd_data,
    input  logic              rom_rdy_n,
    output logic              err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ACC, WAIT, RESP} state_t;

    state_t             state, state_nxt;
    logic               grant, grant_nxt;
    logic               last_grant, last_grant_nxt;
    logic [CNT_W-1:0]   count, count_nxt;
    logic               cs_nxt, as_nxt, rdy0_nxt, rdy1_nxt, err_nxt;
    logic [ADDR_W-1:0]  addr_nxt;
    logic [DATA_W-1:0]  data0_nxt, data1_nxt;
    logic               sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            count      <= '0;
            rom_cs_n   <= 1'b1;
            rom_as_n   <= 1'b1;
            rom_addr   <= '0;
            m0_rd_data <= '0;
            m1_rd_data <= '0;
            m0_rdy_n   <= 1'b1;
            m1_rdy_n   <= 1'b1;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
            count      <= count_nxt;
            rom_cs_n   <= cs_nxt;
            rom_as_n   <= as_nxt;
            rom_addr   <= addr_nxt;
            m0_rd_data <= data0_nxt;
            m1_rd_data <= data1_nxt;
            m0_rdy_n   <= rdy0_nxt;
            m1_rdy_n   <= rdy1_nxt;
            err        <= err_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        count_nxt      = count;
        cs_nxt         = 1'b1;
        as_nxt         = 1'b1;
        addr_nxt       = rom_addr;
        data0_nxt      = m0_rd_data;
        data1_nxt      = m1_rd_data;
        rdy0_nxt       = 1'b1;
        rdy1_nxt       = 1'b1;
        err_nxt        = 1'b0;
        sel            = 1'b0;

        case (state)
            IDLE: begin
                if (!m0_req_n || !m1_req_n) begin
                    // Contention goes to the master that was not served last.
                    sel       = (!m0_req_n && !m1_req_n) ? ~last_grant : m0_req_n;
                    grant_nxt = sel;
                    addr_nxt  = sel ? m1_addr : m0_addr;
                    cs_nxt    = 1'b0;
                    as_nxt    = 1'b0;
                    state_nxt = ACC;
                end
            end
            ACC: begin
                count_nxt = '0;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (!rom_rdy_n) begin
                    if (grant) begin
                        data1_nxt = rom_rd_data;
                        rdy1_nxt  = 1'b0;
                    end else begin
                        data0_nxt = rom_rd_data;
                        rdy0_nxt  = 1'b0;
                    end
                    last_grant_nxt = grant;
                    state_nxt      = RESP;
                end else if (count == CNT_W'(TIMEOUT - 1)) begin
                    if (grant) begin
                        data1_nxt = '0;
                        rdy1_nxt  = 1'b0;
                    end else begin
                        data0_nxt = '0;
                        rdy0_nxt  = 1'b0;
                    end
                    err_nxt        = 1'b1;
                    last_grant_nxt = grant;
                    state_nxt      = RESP;
                end else begin
                    count_nxt = count + 1'b1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// tb/tb_rom_arbiter.sv - scoreboard bench for rom_arbiter
module tb_rom_arbiter;
    localparam int ADDR_W = 11, DATA_W = 32, TIMEOUT = 15;

    logic              clk = 1'b0, reset = 1'b1;
    logic              m0_req_n = 1'b1, m1_req_n = 1'b1;
    logic [ADDR_W-1:0] m0_addr = '0, m1_addr = '0;
    logic [DATA_W-1:0] m0_rd_data, m1_rd_data;
    logic              m0_rdy_n, m1_rdy_n;
    logic              rom_cs_n, rom_as_n, err;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_rd_data = 32'hBAADF00D;
    logic              rom_rdy_n = 1'b1;

    rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .m0_req_n(m0_req_n), .m0_addr(m0_addr), .m0_rd_data(m0_rd_data), .m0_rdy_n(m0_rdy_n),
        .m1_req_n(m1_req_n), .m1_addr(m1_addr), .m1_rd_data(m1_rd_data), .m1_rdy_n(m1_rdy_n),
        .rom_cs_n(rom_cs_n), .rom_as_n(rom_as_n), .rom_addr(rom_addr),
        .rom_rd_data(rom_rd_data), .rom_rdy_n(rom_rdy_n), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          m;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } rec_t;

    rec_t              exp_q[$], obs_q[$];
    logic [ADDR_W-1:0] m0_q[$], m1_q[$];
    logic [ADDR_W-1:0] m1_flip = '0;
    int                cyc = 0, pass_cnt = 0, total_cnt = 0;
    int                rom_delay = 0, rom_cnt = 0;
    bit                rom_dead = 0, rom_pulse = 0;

    function automatic logic [31:0] rom_word(input logic [ADDR_W-1:0] a);
        if (a == 11'h010) return 32'hDEADBEEF;
        return {a, 10'h2A5, a} ^ 32'h0F0F_0000;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // ROM slave: answers the cycle after it sees strobes, optionally delayed.
    always @(posedge clk) begin
        rom_rdy_n   <= 1'b1;
        rom_rd_data <= 32'hBAADF00D;
        if (reset) begin
            rom_cnt <= 0;
        end else if (rom_pulse) begin
            rom_rdy_n   <= 1'b0;
            rom_rd_data <= 32'h12345678;
        end else if (!rom_cs_n && !rom_as_n && !rom_dead) begin
            if (rom_delay == 0) begin
                rom_rdy_n   <= 1'b0;
                rom_rd_data <= rom_word(rom_addr);
            end else begin
                rom_cnt <= rom_delay;
            end
        end else if (rom_cnt > 0) begin
            if (rom_cnt == 1) begin
                rom_rdy_n   <= 1'b0;
                rom_rd_data <= rom_word(rom_addr);
            end
            rom_cnt <= rom_cnt - 1;
        end
    end

    // Master agents: request the head address until its rdy_n strobe.
    always @(negedge clk) begin
        if (!m0_rdy_n && m0_q.size() > 0) void'(m0_q.pop_front());
        if (!m1_rdy_n && m1_q.size() > 0) void'(m1_q.pop_front());
        if (m0_q.size() > 0) begin m0_req_n = 1'b0; m0_addr = m0_q[0]; end
        else m0_req_n = 1'b1;
        if (m1_q.size() > 0) begin m1_req_n = 1'b0; m1_addr = m1_q[0] ^ m1_flip; end
        else m1_req_n = 1'b1;
    end

    always @(negedge clk) begin
        if (!m0_rdy_n) obs_q.push_back('{m: 0, data: m0_rd_data, err: err, cyc: cyc});
        if (!m1_rdy_n) obs_q.push_back('{m: 1, data: m1_rd_data, err: err, cyc: cyc});
        if (err && m0_rdy_n && m1_rdy_n) obs_q.push_back('{m: 2, data: 32'h0, err: err, cyc: cyc});
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        m0_q.delete(); m1_q.delete();
        m1_flip = '0; rom_dead = 0; rom_delay = 0; rom_pulse = 0;
        @(negedge clk);
        reset = 1'b0;
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic wait_obs(input int n);
        for (int i = 0; i < 64 && obs_q.size() < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic push_exp(input int m, input logic [31:0] d, input logic e);
        exp_q.push_back('{m: m, data: d, err: e, cyc: 0});
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++;
        if ({rom_cs_n, rom_as_n, m0_rdy_n, m1_rdy_n, err} !== 5'b11110) $display("FAIL reset_strobes: got %b expected 11110", {rom_cs_n, rom_as_n, m0_rdy_n, m1_rdy_n, err});
        else pass_cnt++;
        total_cnt++;
        if (rom_addr !== '0) $display("FAIL reset_rom_addr: got %h expected 0", rom_addr);
        else pass_cnt++;
        total_cnt++;
        if ({m0_rd_data, m1_rd_data} !== 64'h0) $display("FAIL reset_rd_data: got %h %h expected 0 0", m0_rd_data, m1_rd_data);
        else pass_cnt++;
    endtask

    task automatic test_single_m0();
        int c;
        rec_t e, o;
        do_reset();
        @(posedge clk); #1;
        c = cyc;
        m0_q.push_back(11'h010);
        push_exp(0, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        @(negedge clk);
        total_cnt++;
        if ({rom_cs_n, rom_as_n} !== 2'b00 || rom_addr !== 11'h010) $display("FAIL single_strobe_low: got %b addr %h expected 00 addr 010", {rom_cs_n, rom_as_n}, rom_addr);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({rom_cs_n, rom_as_n} !== 2'b11) $display("FAIL single_strobe_one_cycle: got %b expected 11", {rom_cs_n, rom_as_n});
        else pass_cnt++;
        wait_obs(1);
        if (obs_q.size() > 0) begin
            total_cnt++;
            if (obs_q[0].cyc !== c + 3) $display("FAIL single_latency: got cycle %0d expected %0d", obs_q[0].cyc, c + 3);
            else pass_cnt++;
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total_cnt++;
            if (obs_q.size() == 0) $display("FAIL single_missing: got none expected m%0d %h", e.m, e.data);
            else begin
                o = obs_q.pop_front();
                if (o.m !== e.m || o.data !== e.data || o.err !== e.err) $display("FAIL single_data: got m%0d %h err %b expected m%0d %h err %b", o.m, o.data, o.err, e.m, e.data, e.err);
                else pass_cnt++;
            end
        end
        repeat (3) @(negedge clk);
        total_cnt++;
        if (obs_q.size() != 0) $display("FAIL single_extra: got %0d extra completions expected 0", obs_q.size());
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        int c;
        rec_t e, o;
        do_reset();
        @(posedge clk); #1;
        c = cyc;
        m0_q.push_back(11'h100); m0_q.push_back(11'h101);
        m1_q.push_back(11'h200); m1_q.push_back(11'h201);
        push_exp(0, rom_word(11'h100), 1'b0);
        push_exp(1, rom_word(11'h200), 1'b0);
        push_exp(0, rom_word(11'h101), 1'b0);
        push_exp(1, rom_word(11'h201), 1'b0);
        wait_obs(4);
        for (int i = 0; i < obs_q.size(); i++) begin
            total_cnt++;
            if (obs_q[i].cyc !== c + 3 + 4 * i) $display("FAIL rr_spacing%0d: got cycle %0d expected %0d", i, obs_q[i].cyc, c + 3 + 4 * i);
            else pass_cnt++;
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total_cnt++;
            if (obs_q.size() == 0) $display("FAIL rr_missing: got none expected m%0d %h", e.m, e.data);
            else begin
                o = obs_q.pop_front();
                if (o.m !== e.m || o.data !== e.data || o.err !== e.err) $display("FAIL rr_order: got m%0d %h err %b expected m%0d %h err %b", o.m, o.data, o.err, e.m, e.data, e.err);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_back_to_back();
        int c;
        rec_t e, o;
        do_reset();
        @(posedge clk); #1;
        c = cyc;
        m1_q.push_back(11'h300); m1_q.push_back(11'h301);
        push_exp(1, rom_word(11'h300), 1'b0);
        push_exp(1, rom_word(11'h301), 1'b0);
        wait_obs(2);
        for (int i = 0; i < obs_q.size(); i++) begin
            total_cnt++;
            if (obs_q[i].cyc !== c + 3 + 4 * i) $display("FAIL b2b_spacing%0d: got cycle %0d expected %0d", i, obs_q[i].cyc, c + 3 + 4 * i);
            else pass_cnt++;
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total_cnt++;
            if (obs_q.size() == 0) $display("FAIL b2b_missing: got none expected m%0d %h", e.m, e.data);
            else begin
                o = obs_q.pop_front();
                if (o.m !== e.m || o.data !== e.data || o.err !== e.err) $display("FAIL b2b_data: got m%0d %h err %b expected m%0d %h err %b", o.m, o.data, o.err, e.m, e.data, e.err);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (m0_rd_data !== 32'h0) $display("FAIL b2b_m0_hold: got %h expected 0", m0_rd_data);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        int c;
        rec_t e, o;
        do_reset();
        rom_dead = 1;
        @(posedge clk); #1;
        c = cyc;
        m0_q.push_back(11'h020);
        push_exp(0, 32'h0, 1'b1);
        wait_obs(1);
        if (obs_q.size() > 0) begin
            total_cnt++;
            if (obs_q[0].cyc !== c + 2 + TIMEOUT) $display("FAIL timeout_latency: got cycle %0d expected %0d", obs_q[0].cyc, c + 2 + TIMEOUT);
            else pass_cnt++;
        end
        @(negedge clk);
        total_cnt++;
        if (err !== 1'b0) $display("FAIL timeout_err_pulse: got %b expected 0", err);
        else pass_cnt++;
        rom_dead = 0;
        @(posedge clk); #1;
        m0_q.push_back(11'h030);
        push_exp(0, rom_word(11'h030), 1'b0);
        wait_obs(2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total_cnt++;
            if (obs_q.size() == 0) $display("FAIL timeout_missing: got none expected m%0d %h", e.m, e.data);
            else begin
                o = obs_q.pop_front();
                if (o.m !== e.m || o.data !== e.data || o.err !== e.err) $display("FAIL timeout_data: got m%0d %h err %b expected m%0d %h err %b", o.m, o.data, o.err, e.m, e.data, e.err);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_reset_in_wait();
        rec_t e, o;
        do_reset();
        rom_dead = 1;
        @(posedge clk); #1;
        m0_q.push_back(11'h040);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        m0_q.delete();
        @(negedge clk);
        reset = 1'b0;
        total_cnt++;
        if ({rom_cs_n, rom_as_n, m0_rdy_n, m1_rdy_n, err} !== 5'b11110) $display("FAIL abort_outputs: got %b expected 11110", {rom_cs_n, rom_as_n, m0_rdy_n, m1_rdy_n, err});
        else pass_cnt++;
        @(negedge clk);
        rom_pulse = 1;
        @(negedge clk);
        rom_pulse = 0;
        repeat (4) @(negedge clk);
        total_cnt++;
        if (obs_q.size() != 0) $display("FAIL abort_no_strobe: got %0d completions expected 0", obs_q.size());
        else pass_cnt++;
        obs_q.delete();
        rom_dead = 0;
        @(posedge clk); #1;
        m1_q.push_back(11'h066);
        push_exp(1, rom_word(11'h066), 1'b0);
        wait_obs(1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total_cnt++;
            if (obs_q.size() == 0) $display("FAIL abort_recover_missing: got none expected m%0d %h", e.m, e.data);
            else begin
                o = obs_q.pop_front();
                if (o.m !== e.m || o.data !== e.data || o.err !== e.err) $display("FAIL abort_recover: got m%0d %h err %b expected m%0d %h err %b", o.m, o.data, o.err, e.m, e.data, e.err);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_addr_change();
        rec_t e, o;
        do_reset();
        rom_delay = 3;
        @(posedge clk); #1;
        m1_q.push_back(11'h055);
        push_exp(1, rom_word(11'h055), 1'b0);
        repeat (3) @(negedge clk);
        m1_flip = 11'h7FF;
        @(negedge clk);
        total_cnt++;
        if (rom_addr !== 11'h055) $display("FAIL addr_hold: got %h expected 055", rom_addr);
        else pass_cnt++;
        wait_obs(1);
        m1_flip = '0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total_cnt++;
            if (obs_q.size() == 0) $display("FAIL addr_missing: got none expected m%0d %h", e.m, e.data);
            else begin
                o = obs_q.pop_front();
                if (o.m !== e.m || o.data !== e.data || o.err !== e.err) $display("FAIL addr_data: got m%0d %h err %b expected m%0d %h err %b", o.m, o.data, o.err, e.m, e.data, e.err);
                else pass_cnt++;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_m0();
        test_round_robin();
        test_back_to_back();
        test_timeout();
        test_reset_in_wait();
        test_addr_change();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
